// File: rtl/result_pkg.sv
// Shared definitions for the result collector and its lane writers.
// Holds the collector FSM state type and the default tile geometry, which
// the operand load/stream block also uses so both ends agree on tile shape.
package result_pkg;

  localparam int unsigned RESULT_ROWS       = 32'd4;
  localparam int unsigned RESULT_COLS       = 32'd64;
  localparam int unsigned RESULT_DATA_WIDTH = 32'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collector_state_t;

endpackage

// File: rtl/result_lane_writer.sv
// Per-lane write bookkeeping for the result collector.
// Tracks the column write pointer and the row-full flag of one lane, issues
// the buffer write enable, and flags beats that must be dropped.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       start accepted in IDLE: rewind pointer and full flag
//   collect     collector is in COLLECT
//   drain       collector is in DRAIN
//   in_valid    lane beat valid
//   wr_en       write the lane word at wr_ptr this cycle
//   wr_ptr      current column write pointer
//   row_full    all COLS words of this row captured
//   drop        a beat arrived that cannot be stored
module result_lane_writer #(
  parameter  int unsigned COLS      = 32'd64,
  localparam int unsigned PTR_WIDTH = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 collect,
  input  logic                 drain,
  input  logic                 in_valid,
  output logic                 wr_en,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic                 row_full,
  output logic                 drop
);

  localparam logic [PTR_WIDTH-1:0] LAST_COL = PTR_WIDTH'(COLS - 32'd1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(32'd1);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                 full_q, full_d;

  // Next pointer/full state, write enable and drop detect for this lane.
  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    wr_en  = 1'b0;
    drop   = 1'b0;
    if (clear) begin
      ptr_d  = '0;
      full_d = 1'b0;
    end else if (collect && in_valid) begin
      if (full_q) begin
        drop = 1'b1;
      end else begin
        wr_en = 1'b1;
        // The pointer parks on the last column once the row is full.
        if (ptr_q == LAST_COL) begin
          full_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
    end else if (drain && in_valid) begin
      drop = 1'b1;
    end else begin
      ptr_d  = ptr_q;
      full_d = full_q;
    end
  end

  // Pointer and full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
    end
  end

  assign wr_ptr   = ptr_q;
  assign row_full = full_q;

endmodule

// File: rtl/result_collector.sv
// Receive end of the array datapath.
// Captures ROWS skewed result lanes into a ROWS x COLS buffer, then drains
// the buffer row-major to the host over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse in IDLE arms collection of a new tile
//   in_valid, in_data     per-lane result beats, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   out_valid, out_ready  drain handshake
//   out_data              drain word at (out_row, out_col)
//   busy                  collecting or draining
//   done                  one-cycle pulse after the last drain word is accepted
//   overflow              sticky, a lane beat was dropped
module result_collector
  import result_pkg::*;
#(
  parameter  int unsigned ROWS       = RESULT_ROWS,
  parameter  int unsigned COLS       = RESULT_COLS,
  parameter  int unsigned DATA_WIDTH = RESULT_DATA_WIDTH,
  localparam int unsigned PTR_WIDTH  = $clog2(COLS),
  localparam int unsigned ROW_WIDTH  = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ROWS-1:0]            in_valid,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ROW_WIDTH-1:0]       out_row,
  output logic [PTR_WIDTH-1:0]       out_col,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam logic [PTR_WIDTH-1:0] LAST_COL = PTR_WIDTH'(COLS - 32'd1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(ROWS - 32'd1);
  localparam logic [PTR_WIDTH-1:0] COL_ONE  = PTR_WIDTH'(32'd1);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE  = ROW_WIDTH'(32'd1);

  collector_state_t     state_q, state_d;
  logic [ROW_WIDTH-1:0] rd_row_q, rd_row_d;
  logic [PTR_WIDTH-1:0] rd_col_q, rd_col_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic                 clear_s;
  logic                 collect_s;
  logic                 drain_s;
  logic [ROWS-1:0]      wr_en_s;
  logic [ROWS-1:0]      row_full_s;
  logic [ROWS-1:0]      drop_s;
  logic [PTR_WIDTH-1:0] wr_ptr_s [ROWS];

  logic [DATA_WIDTH-1:0] mem_q [ROWS][COLS];

  assign collect_s = (state_q == COLLECT);
  assign drain_s   = (state_q == DRAIN);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    result_lane_writer #(
      .COLS(COLS)
    ) u_lane_writer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_s),
      .collect  (collect_s),
      .drain    (drain_s),
      .in_valid (in_valid[r]),
      .wr_en    (wr_en_s[r]),
      .wr_ptr   (wr_ptr_s[r]),
      .row_full (row_full_s[r]),
      .drop     (drop_s[r])
    );
  end

  // Next-state, drain pointer, done and sticky overflow logic.
  always_comb begin
    state_d    = state_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    done_d     = 1'b0;
    clear_s    = 1'b0;
    // Lane writers only raise drop in COLLECT or DRAIN, so IDLE traffic is ignored.
    overflow_d = overflow_q | (|drop_s);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          clear_s    = 1'b1;
          rd_row_d   = '0;
          rd_col_d   = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (&row_full_s) begin
          state_d = DRAIN;
        end else begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_col_q == LAST_COL) begin
            rd_col_d = '0;
            if (rd_row_q == LAST_ROW) begin
              rd_row_d = '0;
              state_d  = IDLE;
              done_d   = 1'b1;
            end else begin
              rd_row_d = rd_row_q + ROW_ONE;
            end
          end else begin
            rd_col_d = rd_col_q + COL_ONE;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != IDLE);
  end

  // Control registers; status outputs are decoded ahead and registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Result buffer; contents are only meaningful once written, so no reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (wr_en_s[r]) begin
        mem_q[r][wr_ptr_s[r]] <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_data  = mem_q[rd_row_q][rd_col_q];
  assign out_row   = rd_row_q;
  assign out_col   = rd_col_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Randomized self-checking bench for result_collector.
// The reference model keeps the first COLS beats of every lane as the
// expected tile contents and predicts the drain order, drain entry time,
// done pulse and overflow from the tile-level rules.
module tb_result_collector;

  localparam int ROWS = 4;
  localparam int COLS = 64;
  localparam int DW   = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ROWS-1:0]   in_valid;
  logic [ROWS*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_row;
  logic [5:0]        out_col;
  logic              busy;
  logic              done;
  logic              overflow;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_mem [ROWS][COLS];

  result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm a tile and feed the lanes. kind: 0 = r*256+c, 1 = 0xA000+r*64+c,
  // 2 = random. skew: 0 none, 1 lane r starts r cycles late, 2 random.
  task automatic collect_tile(input int kind, input int skew, input bit gaps, input int extra0);
    int delay [ROWS];
    int sent  [ROWS];
    int t, t_last, first_ov, limit;
    bit all_done;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (kind == 0)      exp_mem[r][c] = 16'(r * 256 + c);
        else if (kind == 1) exp_mem[r][c] = 16'(32'hA000 + r * 64 + c);
        else                exp_mem[r][c] = 16'($urandom_range(0, 65535));
      end
      sent[r]  = 0;
      delay[r] = (skew == 0) ? 0 : (skew == 1) ? r : int'($urandom_range(0, 5));
    end
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("ovf_cleared_by_start", 32'(overflow), 32'd0);
    t = 0;
    t_last = 0;
    first_ov = -1;
    while (t < 800) begin
      if (out_valid === 1'b1 && first_ov < 0) first_ov = t;
      all_done = 1'b1;
      in_valid = '0;
      in_data  = {$urandom, $urandom};
      for (int r = 0; r < ROWS; r++) begin
        limit = COLS + ((r == 0) ? extra0 : 0);
        if (sent[r] < limit) begin
          all_done = 1'b0;
          if (t >= delay[r] && (!gaps || $urandom_range(0, 3) != 0)) begin
            in_valid[r] = 1'b1;
            if (sent[r] < COLS) in_data[r*DW +: DW] = exp_mem[r][sent[r]];
            if (sent[r] == COLS - 1 && t > t_last) t_last = t;
            sent[r]++;
          end
        end
      end
      if (all_done && first_ov >= 0) break;
      tick();
      t++;
    end
    in_valid = '0;
    check_val("drain_entry_cycle", 32'(first_ov), 32'(t_last + 2));
  endtask

  // Drain and check the tile. bp: 0 ready high, 1 pattern 1,0,0,1, 2 random.
  // inject_at: drain index that sees a start pulse plus all lanes valid.
  // reset_at: drain index at which reset is asserted.
  task automatic drain_tile(input int bp, input int inject_at, input int reset_at, input bit exp_ovf);
    int idx, cyc, r, c, ndone;
    bit acc, ovf_model;
    idx = 0;
    cyc = 0;
    ndone = 0;
    ovf_model = exp_ovf;
    while (idx < ROWS * COLS && cyc < 4000) begin
      r = idx / COLS;
      c = idx % COLS;
      check_val("drain_valid", 32'(out_valid), 32'd1);
      check_val("drain_busy", 32'(busy), 32'd1);
      check_val("drain_row", 32'(out_row), 32'(r));
      check_val("drain_col", 32'(out_col), 32'(c));
      check_val("drain_data", 32'(out_data), 32'(exp_mem[r][c]));
      check_val("drain_ovf", 32'(overflow), 32'(ovf_model));
      if (done === 1'b1) ndone++;
      if (idx == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        tick();
        check_val("rst_done_after", 32'(done), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        tick();
        check_val("rst_no_done", 32'(done), 32'd0);
        check_val("rst_idle", 32'(busy), 32'd0);
        return;
      end
      if (bp == 0)      out_ready = 1'b1;
      else if (bp == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else              out_ready = 1'($urandom_range(0, 1));
      if (idx == inject_at) begin
        start = 1'b1;
        in_valid = 4'hF;
        ovf_model = 1'b1;
      end
      acc = out_ready;
      tick();
      cyc++;
      start = 1'b0;
      in_valid = '0;
      if (acc) idx++;
    end
    out_ready = 1'b0;
    check_val("drain_count", 32'(idx), 32'(ROWS * COLS));
    check_val("early_done", 32'(ndone), 32'd0);
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("done_valid_low", 32'(out_valid), 32'd0);
    check_val("done_busy_low", 32'(busy), 32'd0);
    check_val("done_ovf", 32'(overflow), 32'(ovf_model));
    tick();
    check_val("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", 32'(out_valid), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Aligned lanes, counting pattern, ready held high.
    collect_tile(0, 0, 1'b0, 0);
    check_val("t1_ovf", 32'(overflow), 32'd0);
    drain_tile(0, -1, -1, 1'b0);

    // Lane traffic in IDLE is ignored.
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();
    check_val("idle_ovf", 32'(overflow), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Lane r starts r cycles late.
    collect_tile(1, 1, 1'b0, 0);
    drain_tile(0, -1, -1, 1'b0);

    // Random data with gaps, 1,0,0,1 backpressure.
    collect_tile(2, 2, 1'b1, 0);
    drain_tile(1, -1, -1, 1'b0);

    // Lane 0 sends one beat too many.
    collect_tile(2, 2, 1'b1, 1);
    check_val("t4_ovf", 32'(overflow), 32'd1);
    drain_tile(2, -1, -1, 1'b1);

    // Start and lane beats during drain are ignored but set overflow.
    collect_tile(2, 0, 1'b0, 0);
    drain_tile(0, 10, -1, 1'b0);

    // Reset mid-drain, then a fresh tile.
    collect_tile(2, 2, 1'b1, 0);
    drain_tile(0, -1, 100, 1'b0);
    collect_tile(2, 2, 1'b1, 0);
    drain_tile(2, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
